// File: rtl/race_pkg.sv
// Shared constants, state/lane types and lane-to-x mapping for the race sequencer.
package race_pkg;
  localparam logic [9:0] LANE_L   = 10'd197;
  localparam logic [9:0] LANE_C   = 10'd279;
  localparam logic [9:0] LANE_R   = 10'd361;
  localparam logic [9:0] CAR_Y    = 10'd357;
  localparam logic [9:0] SPR_H    = 10'd121;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  // First row below the car; obstacle top must be above it to overlap.
  localparam logic [9:0] CAR_BOT  = CAR_Y + SPR_H;

  localparam logic [3:0] SPEED_INIT = 4'd2;
  localparam logic [3:0] SPEED_MAX  = 4'd8;
  // Counters compare against the last count so they wrap to 0 on the tick.
  localparam logic [9:0] LEVEL_LAST = 10'd599;  // LEVEL_FRAMES - 1
  localparam logic [6:0] CRASH_LAST = 7'd119;   // CRASH_FRAMES - 1

  typedef enum logic [1:0] {IDLE, PLAY, CRASH} state_e;

  typedef logic [1:0] lane_t;
  localparam lane_t LN_L = 2'd0;
  localparam lane_t LN_C = 2'd1;
  localparam lane_t LN_R = 2'd2;

  function automatic logic [9:0] lane_x(input lane_t l);
    case (l)
      LN_L:    return LANE_L;
      LN_R:    return LANE_R;
      default: return LANE_C;
    endcase
  endfunction
endpackage

// File: rtl/race_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16/14/13/11), advances every clock.
module race_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr_o
);
  logic [15:0] lfsr_q;

  // Shift right, feedback from taps into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/race_game_ctrl.sv
// Per-frame game sequencer: lane moves, one falling obstacle, bar scroll, collision.
// All game state changes on the cycle frame_tick is high, so outputs hold all frame.
module race_game_ctrl
  import race_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        left,
  input  logic        right,
  input  logic        start,
  output logic [9:0]  car_x,
  output logic [9:0]  car_y,
  output logic [9:0]  obs_x,
  output logic [9:0]  obs_y,
  output logic        obs_valid,
  output logic [5:0]  bar_scroll,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic        crash,
  output logic        frame_tick
);
  state_e      state_q, state_d;
  lane_t       car_lane_q, car_lane_d, obs_lane_q, obs_lane_d, lane_mv;
  logic [9:0]  obs_y_q, obs_y_d, lvl_q, lvl_d;
  logic        obs_v_q, obs_v_d;
  logic [5:0]  bar_q, bar_d;
  logic [3:0]  spd_q, spd_d;
  logic [15:0] score_q, score_d;
  logic [6:0]  crc_q, crc_d;
  logic        tick_q;
  logic [2:0]  l_sync_q, r_sync_q, s_sync_q;  // [0],[1] synchroniser, [2] edge history
  logic        pend_l_q, pend_l_d, pend_r_q, pend_r_d, pend_s_q, pend_s_d;
  logic        rise_l, rise_r, rise_s;
  logic [10:0] obs_sum;
  logic [15:0] lfsr;
  logic        unused_lfsr;

  race_lfsr16 #(.SEED(16'hACE1)) u_lfsr (.clk(clk), .rst_n(reset), .lfsr_o(lfsr));
  assign unused_lfsr = ^lfsr[15:2];

  assign rise_l = l_sync_q[1] & ~l_sync_q[2];
  assign rise_r = r_sync_q[1] & ~r_sync_q[2];
  assign rise_s = s_sync_q[1] & ~s_sync_q[2];

  // Next-state: pending flags every cycle, game state only on the frame tick.
  always_comb begin
    state_d    = state_q;
    car_lane_d = car_lane_q;
    obs_lane_d = obs_lane_q;
    obs_y_d    = obs_y_q;
    obs_v_d    = obs_v_q;
    bar_d      = bar_q;
    spd_d      = spd_q;
    score_d    = score_q;
    lvl_d      = lvl_q;
    crc_d      = crc_q;
    lane_mv    = car_lane_q;
    obs_sum    = {1'b0, obs_y_q} + {7'd0, spd_q};
    pend_l_d   = (tick_q || state_q == CRASH) ? 1'b0 : (pend_l_q | rise_l);
    pend_r_d   = (tick_q || state_q == CRASH) ? 1'b0 : (pend_r_q | rise_r);
    pend_s_d   = tick_q ? 1'b0 : (pend_s_q | (rise_s && state_q == IDLE));
    if (tick_q) begin
      case (state_q)
        IDLE: begin
          if (pend_s_q) begin
            score_d = 16'd0;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (pend_l_q && !pend_r_q && car_lane_q != LN_L)      lane_mv = car_lane_q - 2'd1;
          else if (pend_r_q && !pend_l_q && car_lane_q != LN_R) lane_mv = car_lane_q + 2'd1;
          car_lane_d = lane_mv;
          if (!obs_v_q) begin
            // Code 3 targets the player's lane after this tick's move.
            obs_v_d    = 1'b1;
            obs_y_d    = 10'd0;
            obs_lane_d = (lfsr[1:0] == 2'd3) ? lane_mv : lfsr[1:0];
          end else begin
            obs_y_d = obs_sum[9:0];
            if (obs_sum >= {1'b0, V_ACTIVE}) begin
              obs_v_d = 1'b0;
              if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            end
          end
          bar_d = bar_q + {2'd0, spd_q};
          if (lvl_q == LEVEL_LAST) begin
            lvl_d = 10'd0;
            if (spd_q != SPEED_MAX) spd_d = spd_q + 4'd1;
          end else begin
            lvl_d = lvl_q + 10'd1;
          end
          if (obs_v_d && obs_lane_d == lane_mv &&
              ({1'b0, obs_y_d} + {1'b0, SPR_H}) > {1'b0, CAR_Y} && obs_y_d < CAR_BOT)
            state_d = CRASH;
        end
        CRASH: begin
          if (crc_q == CRASH_LAST) begin
            state_d    = IDLE;
            car_lane_d = LN_C;
            obs_lane_d = LN_C;
            obs_y_d    = 10'd0;
            obs_v_d    = 1'b0;
            bar_d      = 6'd0;
            spd_d      = SPEED_INIT;
            lvl_d      = 10'd0;
            crc_d      = 7'd0;
          end else begin
            crc_d = crc_q + 7'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers, synchronisers and the registered frame tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      car_lane_q <= LN_C;
      obs_lane_q <= LN_C;
      obs_y_q    <= 10'd0;
      obs_v_q    <= 1'b0;
      bar_q      <= 6'd0;
      spd_q      <= SPEED_INIT;
      score_q    <= 16'd0;
      lvl_q      <= 10'd0;
      crc_q      <= 7'd0;
      tick_q     <= 1'b0;
      l_sync_q   <= 3'd0;
      r_sync_q   <= 3'd0;
      s_sync_q   <= 3'd0;
      pend_l_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      pend_s_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      car_lane_q <= car_lane_d;
      obs_lane_q <= obs_lane_d;
      obs_y_q    <= obs_y_d;
      obs_v_q    <= obs_v_d;
      bar_q      <= bar_d;
      spd_q      <= spd_d;
      score_q    <= score_d;
      lvl_q      <= lvl_d;
      crc_q      <= crc_d;
      tick_q     <= (vcount == V_ACTIVE) && (hcount == 10'd0);
      l_sync_q   <= {l_sync_q[1:0], left};
      r_sync_q   <= {r_sync_q[1:0], right};
      s_sync_q   <= {s_sync_q[1:0], start};
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      pend_s_q   <= pend_s_d;
    end
  end

  assign car_x      = lane_x(car_lane_q);
  assign car_y      = CAR_Y;
  assign obs_x      = lane_x(obs_lane_q);
  assign obs_y      = obs_y_q;
  assign obs_valid  = obs_v_q;
  assign bar_scroll = bar_q;
  assign speed      = spd_q;
  assign score      = score_q;
  assign crash      = (state_q == CRASH);
  assign frame_tick = tick_q;
endmodule
